// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: issues a req/ack transaction for loads and
// stores, aligns/extends load data into RD and stalls the upstream pipeline
// until the access completes (or errors out).
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] ADDR,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // state | meaning
  // IDLE  | waiting for a load/store from EX_MEM
  // REQ   | bus request outstanding, waiting for mem_ack or timeout
  // DONE  | access finished; MEM_WB captures RD, pipeline advances
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic        uns_q, uns_d, aerr_q, aerr_d, berr_q, berr_d;

  logic        access, misaligned, timeout_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, lane, ld_ext;

  assign access      = mem_read | mem_write;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Lane enables, replicated store data and alignment check for the incoming access.
  always_comb begin
    be_new     = 4'b1111;
    wdata_new  = WD;
    misaligned = 1'b0;
    case (size)
      2'b00: begin
        be_new    = 4'b0001 << ADDR[1:0];
        wdata_new = {4{WD[7:0]}};
      end
      2'b01: begin
        be_new     = ADDR[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{WD[15:0]}};
        misaligned = ADDR[0];
      end
      default: misaligned = |ADDR[1:0];
    endcase
  end

  // Shift the addressed lane down and extend it to 32 bits.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld_ext = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  // Next-state logic, stall generation and bus register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (misaligned) begin
            state_d = DONE;
            aerr_d  = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {ADDR[31:2], 2'b00};
            wdata_d = wdata_new;
            be_d    = be_new;
            size_d  = size;
            off_d   = ADDR[1:0];
            uns_d   = ld_unsigned;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rd_d = ld_ext;
        end else if (timeout_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
    end
  end

  assign RD        = rd_q;
  assign align_err = aerr_q;
  assign bus_err   = berr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: each access pushes its expected
// outcome, the DONE cycle pops and compares it.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, ld_unsigned = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] ADDR = '0, WD = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] RD, mem_addr, mem_wdata;
  logic        stall, align_err, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rd;
    logic [3:0]  be;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        al;
    logic        bus;
    int          stall_n;
    int          req_n;
  } exp_t;

  exp_t sb[$];

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .ld_unsigned(ld_unsigned), .ADDR(ADDR), .WD(WD),
    .RD(RD), .stall(stall), .align_err(align_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // k = REQ cycle (1-based) in which mem_ack is given; 0 = never ack
  task automatic do_access(input logic rd_i, input logic wr_i, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdata, input int k,
                           input logic [31:0] e_rd, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic e_al,
                           input logic e_bus, input int e_stall);
    exp_t e, p;
    int stall_n, req_n;
    logic got;
    logic [3:0]  c_be;
    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    e.rd = e_rd; e.be = e_be; e.we = wr_i; e.addr = {a[31:2], 2'b00};
    e.wdata = e_wdata; e.al = e_al; e.bus = e_bus; e.stall_n = e_stall;
    e.req_n = e_al ? 0 : ((k == 0) ? 16 : k);
    sb.push_back(e);
    @(negedge clk);
    mem_read = rd_i; mem_write = wr_i; size = sz; ld_unsigned = uns; ADDR = a; WD = wd;
    stall_n = 0; req_n = 0; got = 1'b0;
    c_be = '0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall) begin
        got = 1'b1;
        break;
      end
      stall_n++;
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          c_be = mem_be; c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
        end
        if (req_n == k) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    if (!got) begin
      check_val("done_wait", 32'd0, 32'd1);
    end else begin
      p = sb.pop_front();
      check_val("rd", RD, p.rd);
      check_val("align_err", {31'd0, align_err}, {31'd0, p.al});
      check_val("bus_err", {31'd0, bus_err}, {31'd0, p.bus});
      check_val("req_in_done", {31'd0, mem_req}, 32'd0);
      check_val("stall_cycles", stall_n, p.stall_n);
      check_val("req_cycles", req_n, p.req_n);
      if (p.req_n > 0) begin
        check_val("be", {28'd0, c_be}, {28'd0, p.be});
        check_val("we", {31'd0, c_we}, {31'd0, p.we});
        check_val("addr", c_addr, p.addr);
        if (p.we) check_val("wdata", c_wdata, p.wdata);
      end
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_val("err_pulse", {30'd0, align_err, bus_err}, 32'd0);
    check_val("idle_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_rd", RD, 32'd0);
    check_val("rst_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_bus", {mem_be, mem_we, align_err, bus_err, stall}, 8'd0);
    check_val("rst_addr", mem_addr | mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_access(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 3);
    do_access(1, 0, 2'b00, 0, 32'h103, 0, 32'h80123456, 1, 32'hFFFFFF80, 4'b1000, 0, 0, 0, 2);
    do_access(1, 0, 2'b00, 1, 32'h103, 0, 32'h80123456, 1, 32'h00000080, 4'b1000, 0, 0, 0, 2);
    do_access(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 0, 3, 32'h00000080, 4'b1100, 32'hABCDABCD, 0, 0, 4);
    do_access(1, 0, 2'b10, 0, 32'h101, 0, 0, 1, 32'h00000080, 4'b0000, 0, 1, 0, 1);
    do_access(1, 0, 2'b01, 0, 32'h102, 0, 32'h80011234, 1, 32'hFFFF8001, 4'b1100, 0, 0, 0, 2);
    do_access(1, 1, 2'b00, 0, 32'h001, 32'h12345655, 32'hCAFEF00D, 1, 32'hFFFF8001, 4'b0010, 32'h55555555, 0, 0, 2);
    do_access(0, 1, 2'b01, 0, 32'h003, 32'h1, 0, 1, 32'hFFFF8001, 4'b0000, 0, 1, 0, 1);
    do_access(1, 0, 2'b11, 0, 32'h008, 0, 32'h12345678, 1, 32'h12345678, 4'b1111, 0, 0, 0, 2);
    do_access(1, 0, 2'b00, 1, 32'h102, 0, 32'h00AB0000, 2, 32'h000000AB, 4'b0100, 0, 0, 0, 3);
    do_access(1, 0, 2'b10, 0, 32'h040, 0, 0, 0, 32'h00000000, 4'b1111, 0, 0, 1, 17);
    do_access(1, 0, 2'b01, 1, 32'h300, 0, 32'h5555F00D, 1, 32'h0000F00D, 4'b0011, 0, 0, 0, 2);

    // stray ack while idle must be ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check_val("stray_ack_rd", RD, 32'h0000F00D);
    check_val("stray_ack_req", {31'd0, mem_req}, 32'd0);

    // reset in the middle of a REQ phase
    @(negedge clk);
    mem_read = 1'b1; size = 2'b10; ADDR = 32'h500;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("mid_req_up", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    #1;
    check_val("rst_mid_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_mid_rd", RD, 32'd0);
    check_val("rst_mid_bus", {mem_be, mem_we, align_err, bus_err, stall}, 8'd0);
    check_val("rst_mid_addr", mem_addr | mem_wdata, 32'd0);
    rst = 1'b0;

    do_access(1, 0, 2'b10, 0, 32'h104, 0, 32'h0BADF00D, 1, 32'h0BADF00D, 4'b1111, 0, 0, 0, 2);

    check_val("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
